reset_seq: RTL
==============

# reset_seq

Parametrised reset sequencer: successor to the fixed 8-cycle reset stretcher between the MMCM and the picorv32 top. Holds every reset domain low until the PLL lock is synchronised and debounced, stretches for a programmable count, then releases `NUM_STAGES` active-low resets in order (stage 0 first: interconnect, then CPU, then peripherals). Re-enters reset on lock loss or a software request and records the cause for firmware.

## Interface
- `NUM_STAGES`, 2: number of sequenced reset outputs, 1..8.
- `STRETCH_CYCLES`, 8: cycles held after the lock filter passes, 1..2^16-1.
- `STAGE_GAP`, 4: cycles between release of consecutive stages, 1..255.
- `LOCK_FILTER`, 4: consecutive cycles the synchronised lock must be high, 1..255.
- `clk  in  1`: system clock (CLK_OUT1 domain).
- `resetn  in  1`: asynchronous, active-low reset of the block itself (board reset button).
- `pll_locked  in  1`: MMCM LOCKED, asynchronous to `clk`.
- `sw_rst_req  in  1`: synchronous single-cycle software reset request.
- `rst_n  out  NUM_STAGES`: sequenced active-low resets, registered; reset value all 0.
- `rst_busy  out  1`: high whenever the FSM is not in RUN; reset value 1.
- `rst_cause  out  2`: 00 power-on/button, 01 lock loss, 10 software; reset value 00.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `lock_s`; both flops reset to 0.
- States: HOLD, FILTER, STRETCH, RELEASE, RUN. Reset state is HOLD.
- HOLD: all `rst_n` = 0. Go to FILTER when `lock_s` = 1.
- FILTER: counter increments while `lock_s` = 1; go to STRETCH when it reaches `LOCK_FILTER`. `lock_s` = 0 returns to HOLD and clears the counter.
- STRETCH: counter runs to `STRETCH_CYCLES`, then go to RELEASE and set `rst_n[0]`.
- RELEASE: every `STAGE_GAP` cycles, set the next bit of `rst_n`. After `rst_n[NUM_STAGES-1]` is set, go to RUN. With `NUM_STAGES` = 1, STRETCH goes directly to RUN.
- RUN: `rst_busy` = 0.
- Lock loss: `lock_s` = 0 in STRETCH, RELEASE or RUN gives HOLD on the next edge. All `rst_n` are cleared on that edge and `rst_cause` = 01.
- Software reset: `sw_rst_req` is honoured only in RUN. It gives HOLD with `rst_cause` = 10. It is ignored in every other state.
- Simultaneous lock loss and `sw_rst_req` in RUN: lock loss wins and `rst_cause` = 01.
- `rst_cause` updates only on entry to HOLD from a non-reset path, and holds until the next entry.
- `resetn` asserted in any state: all flops clear asynchronously. Outputs take their reset values immediately with no clock. Release is then synchronous through the normal sequence.
- Counters are sized with `$clog2(max+1)`, saturate at their terminal value, and clear on every state change.

## Timing
- `rst_n` bits are only ever cleared together and set one at a time. They never glitch high during HOLD, FILTER or STRETCH.
- Edge 1 is the first rising edge with `resetn` high and `pll_locked` steady high.
- `lock_s` is high after edge 2.
- FILTER is entered at edge 3, STRETCH at edge 3+`LOCK_FILTER`.
- `rst_n[0]` rises at edge 3+`LOCK_FILTER`+`STRETCH_CYCLES`. With defaults this is edge 15.
- `rst_n[k]` rises `k*STAGE_GAP` edges after `rst_n[0]`. With defaults `rst_n[1]` rises at edge 19, and `rst_busy` falls on that same edge.
- Lock-loss response: 2 sync edges plus 1 edge, so `rst_n` is all 0 on the third edge after `pll_locked` falls.
- Software reset: `rst_n` is all 0 on the edge after the `sw_rst_req` cycle.
- Re-release after HOLD follows the full FILTER→STRETCH→RELEASE latency above, counted from `lock_s` high.

## Structure
- Shared package `reset_seq_pkg`: state enum (HOLD, FILTER, STRETCH, RELEASE, RUN) and cause constants `CAUSE_POR`=2'b00, `CAUSE_LOCK`=2'b01, `CAUSE_SW`=2'b10.
- Sub-module `sync_2ff`: a one-bit two-flop synchroniser with async active-low reset, reused for other CDC inputs.
- `chip` replaces `reset_gen` with `reset_seq`, driving `resetn` from FPGA_RESET. `rst_n[0]` feeds the bus and `rst_n[1]` feeds `top`.

## Test plan
- Power-on, defaults, `pll_locked`=1: `rst_n[0]`↑ at edge 15, `rst_n[1]`↑ at edge 19, `rst_busy`↓ at edge 19, `rst_cause`=00.
- Lock chatter: `pll_locked` toggles high 3 cycles / low 1 cycle during FILTER. FSM never leaves FILTER/HOLD, `rst_n` stays 00. Then a steady high releases with the normal latency.
- Lock loss in RUN: drop `pll_locked` at edge 40. `rst_n`=00 at edge 43, `rst_cause`=01, `rst_busy`=1. Restore lock: full sequence repeats.
- Software reset: 1-cycle `sw_rst_req` in RUN. `rst_n`=00 next edge, `rst_cause`=10. A pulse during RELEASE is ignored and `rst_cause` is unchanged.
- Collision: `sw_rst_req` in the same cycle `lock_s` falls, in RUN. `rst_cause`=01.
- Async reset mid-RELEASE (`rst_n`=01): assert `resetn` between edges. `rst_n`=00, `rst_busy`=1, `rst_cause`=00 immediately. Run a second configuration, `NUM_STAGES`=4 and `STAGE_GAP`=1, to check that stages release on consecutive edges.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, reset-cause
// codes and a small helper used to size the shared counter.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    FILTER  = 3'd1,
    STRETCH = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_sync_2ff.sv
// One-bit two-flop synchroniser with asynchronous active-low reset; both
// stages clear to 0 so a reset always reads as "not asserted" downstream.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: waits for a synchronised, debounced PLL lock, stretches,
// then releases NUM_STAGES active-low resets in order; records why it re-entered reset.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 2,
  parameter int STRETCH_CYCLES = 8,
  parameter int STAGE_GAP      = 4,
  parameter int LOCK_FILTER    = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pll_locked,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_n,
  output logic                  rst_busy,
  output logic [1:0]            rst_cause,
  output state_e                dbg_state
);

  localparam int CNT_MAX = max_of(max_of(LOCK_FILTER, STRETCH_CYCLES), STAGE_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [NUM_STAGES-1:0] STAGE0  = NUM_STAGES'(1);

  logic lock_s;

  state_e                state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q, cnt_inc;
  logic [NUM_STAGES-1:0] rst_n_d, rst_n_q;
  logic [1:0]            cause_d, cause_q;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (pll_locked),
    .q     (lock_s)
  );

  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    rst_n_d = rst_n_q;
    cause_d = cause_q;

    unique case (state_q)
      HOLD: begin
        if (lock_s) state_d = FILTER;
      end
      FILTER: begin
        if (!lock_s)                   state_d = HOLD;
        else if (cnt_q == FILTER_LAST) state_d = STRETCH;
      end
      STRETCH: begin
        if (lock_s && cnt_q == STRETCH_LAST) begin
          rst_n_d = STAGE0;
          state_d = rst_n_d[NUM_STAGES-1] ? RUN : RELEASE;
        end
      end
      RELEASE: begin
        // Stay in RELEASE between stages, so the gap counter restarts explicitly.
        if (lock_s && cnt_q == GAP_LAST) begin
          rst_n_d = (rst_n_q << 1) | STAGE0;
          cnt_d   = '0;
          if (rst_n_d[NUM_STAGES-1]) state_d = RUN;
        end
      end
      RUN: begin
        if (lock_s && sw_rst_req) begin
          state_d = HOLD;
          cause_d = CAUSE_SW;
        end
      end
      default: state_d = HOLD;
    endcase

    // Lock loss after qualification overrides everything, including a software request.
    if ((state_q inside {STRETCH, RELEASE, RUN}) && !lock_s) begin
      state_d = HOLD;
      cause_d = CAUSE_LOCK;
    end

    if (state_d != state_q) cnt_d = '0;
    if (state_d == HOLD)    rst_n_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_n_q <= '0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      cause_q <= cause_d;
    end
  end

  assign rst_n     = rst_n_q;
  assign rst_busy  = (state_q != RUN);
  assign rst_cause = cause_q;
  assign dbg_state = state_q;

endmodule
